// File: rtl/griffin_rounds.sv
// griffin_rounds: round sequencer for the Griffin permutation.
// Steers the state through external nonlinear, linear and ROM units.
module griffin_rounds #(
  parameter int N_BITS      = 254,
  parameter int STATE_SIZE  = 3,
  parameter int NUM_ROUNDS  = 14,
  parameter int LIN_LATENCY = 1,
  parameter int INIT_LINEAR = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [STATE_SIZE*N_BITS-1:0]         in_state,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [STATE_SIZE*N_BITS-1:0]         out_state,
  output logic [$clog2(NUM_ROUNDS)-1:0]        rc_addr,
  input  logic [STATE_SIZE*N_BITS-1:0]         rc_data,
  output logic                                 nl_start,
  output logic [STATE_SIZE*N_BITS-1:0]         nl_state_in,
  input  logic                                 nl_done,
  input  logic [STATE_SIZE*N_BITS-1:0]         nl_state_out,
  output logic [STATE_SIZE*N_BITS-1:0]         lin_state_in,
  output logic [STATE_SIZE*N_BITS-1:0]         lin_rc,
  input  logic [STATE_SIZE*N_BITS-1:0]         lin_state_out,
  output logic                                 busy,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]      round
);

  localparam int W  = STATE_SIZE * N_BITS;
  localparam int AW = $clog2(NUM_ROUNDS);
  localparam int RW = $clog2(NUM_ROUNDS + 1);
  localparam int CW = $clog2(LIN_LATENCY + 1);
  localparam logic [RW-1:0] LAST  = RW'(NUM_ROUNDS - 1);
  localparam logic [CW-1:0] CLAST = CW'(LIN_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, PRE_LIN, NL_RUN, NL_WAIT, LIN_WAIT, OUT
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [W-1:0]  st;
  logic [W-1:0]  rc_q;
  logic [RW-1:0] rnd;
  logic [CW-1:0] cnt;
  logic          rc_pend;
  logic          lin_end;
  logic          last_rnd;

  assign lin_end  = (cnt == CLAST);
  assign last_rnd = (rnd == LAST);

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:
        if (in_valid)
          nxt = (INIT_LINEAR != 0) ? PRE_LIN : NL_RUN;
      PRE_LIN:
        if (lin_end) nxt = NL_RUN;
      NL_RUN:
        nxt = NL_WAIT;
      NL_WAIT:
        if (nl_done) nxt = LIN_WAIT;
      LIN_WAIT:
        if (lin_end) nxt = last_rnd ? OUT : NL_RUN;
      OUT:
        if (out_ready) nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= IDLE;
      st      <= '0;
      rc_q    <= '0;
      rnd     <= '0;
      cnt     <= '0;
      rc_pend <= 1'b0;
    end else begin
      cur     <= nxt;
      // ROM answers one cycle after the address seen in NL_RUN
      rc_pend <= (cur == NL_RUN);
      if (rc_pend) rc_q <= rc_data;
      if (cur == PRE_LIN || cur == LIN_WAIT)
        cnt <= lin_end ? '0 : cnt + 1'b1;
      else
        cnt <= '0;
      case (cur)
        IDLE:
          if (in_valid) begin
            st  <= in_state;
            rnd <= '0;
          end
        PRE_LIN:
          if (lin_end) st <= lin_state_out;
        NL_WAIT:
          if (nl_done) st <= nl_state_out;
        LIN_WAIT:
          if (lin_end) begin
            st <= lin_state_out;
            if (!last_rnd) rnd <= rnd + 1'b1;
          end
        default: ;
      endcase
    end
  end

  assign in_ready     = (cur == IDLE);
  assign out_valid    = (cur == OUT);
  assign nl_start     = (cur == NL_RUN);
  assign busy         = (cur != IDLE);
  assign round        = rnd;
  assign rc_addr      = rnd[AW-1:0];
  assign out_state    = st;
  assign nl_state_in  = st;
  assign lin_state_in = st;
  // the final round carries no constants
  assign lin_rc = (cur == LIN_WAIT && !last_rnd) ? rc_q : '0;

endmodule

// File: doc/griffin_rounds.md
GRIFFIN_ROUNDS -- requirements
Module: griffin_rounds

Interface
REQ-001 Parameter N_BITS, default 254, field element width.
REQ-002 Parameter STATE_SIZE, default 3, number of state elements.
REQ-003 Parameter NUM_ROUNDS, default 14, rounds per permutation (>=2).
REQ-004 Parameter LIN_LATENCY, default 1, fixed cycles from lin_state_in/lin_rc valid to lin_state_out valid (>=1).
REQ-005 Parameter INIT_LINEAR, default 1, if 1 an initial linear layer with zero constants precedes round 0.
REQ-006 clk  input  1  clock, all logic rising-edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 in_valid / in_ready  input / output  1 / 1  input state handshake.
REQ-009 in_state  input  STATE_SIZE*N_BITS  permutation input, element i at bits [i*N_BITS +: N_BITS].
REQ-010 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-011 out_state  output  STATE_SIZE*N_BITS  permutation result.
REQ-012 rc_addr  output  $clog2(NUM_ROUNDS)  round-constant ROM address; rc_data  input  STATE_SIZE*N_BITS  ROM data, valid exactly 1 cycle after rc_addr.
REQ-013 nl_start  output  1  one-cycle start pulse to nonlinear unit; nl_state_in  output  STATE_SIZE*N_BITS.
REQ-014 nl_done  input  1  nonlinear completion pulse; nl_state_out  input  STATE_SIZE*N_BITS, valid when nl_done=1.
REQ-015 lin_state_in, lin_rc  output  STATE_SIZE*N_BITS each  linear-layer operands; lin_state_out  input  STATE_SIZE*N_BITS.
REQ-016 busy  output  1  high in every state except IDLE; round  output  $clog2(NUM_ROUNDS+1)  current round index.

Function
REQ-017 States: IDLE, PRE_LIN, NL_RUN, NL_WAIT, LIN_WAIT, OUT; encoding free.
REQ-018 IDLE: in_ready=1; on in_valid, capture in_state into state register, round<=0, go PRE_LIN if INIT_LINEAR=1 else NL_RUN.
REQ-019 in_ready=0 in all states except IDLE; in_valid outside IDLE is ignored.
REQ-020 PRE_LIN: lin_state_in=state register, lin_rc=0; wait LIN_LATENCY cycles, then capture lin_state_out into state register, go NL_RUN.
REQ-021 NL_RUN: assert nl_start for exactly one cycle with nl_state_in=state register; drive rc_addr=round in the same cycle; go NL_WAIT next cycle.
REQ-022 NL_WAIT: hold nl_state_in stable; register rc_data on the cycle after NL_RUN; on nl_done capture nl_state_out into state register, go LIN_WAIT.
REQ-023 nl_done arriving in the cycle directly after nl_start SHALL be accepted (minimum nonlinear latency 1).
REQ-024 LIN_WAIT: lin_state_in=state register; lin_rc=registered rc_data, except lin_rc=0 when round=NUM_ROUNDS-1 (final round has no constants); after LIN_LATENCY cycles capture lin_state_out.
REQ-025 End of LIN_WAIT: if round=NUM_ROUNDS-1 go OUT, else round<=round+1 and go NL_RUN.
REQ-026 OUT: out_valid=1, out_state=state register, held stable until out_ready; on out_valid&&out_ready go IDLE.
REQ-027 out_valid and in_ready never both 1; next input accepted no earlier than the cycle after the output handshake.
REQ-028 Spurious nl_done outside NL_WAIT SHALL be ignored.
REQ-029 The block performs no field arithmetic; modular reduction is the responsibility of attached units.
REQ-030 Latency in_valid accept to out_valid (immediate nl_done, LIN_LATENCY=L) = 1 + INIT_LINEAR*L + NUM_ROUNDS*(2+L) cycles; verify as equality.

Reset
REQ-031 reset=1 at a clock edge: state IDLE, round=0, out_valid=0, nl_start=0, busy=0, in_ready=1 the following cycle; rc_addr=0, out_state=0.
REQ-032 reset asserted mid-permutation aborts it; no out_valid follows; a late nl_done after reset is ignored.

Verification
REQ-033 Defaults, behavioural nonlinear (done 1 cycle after start) and linear models, one vector -> out_state equals golden Griffin-Pi output, latency 1+1+14*3=44 cycles.
REQ-034 Nonlinear model with random done delay 1..20 cycles -> identical out_state; exactly 14 nl_start pulses; rc_addr sequence 0..13.
REQ-035 Final round check: ROM returns all-ones for address 13 -> lin_rc observed 0 in round 13, out_state unaffected.
REQ-036 out_ready held low 10 cycles in OUT -> out_state stable, in_ready=0, new in_valid ignored; accept occurs after out_ready.
REQ-037 reset pulsed during round 5 -> out_valid never asserted, busy=0 next cycle; next input processed correctly.
REQ-038 INIT_LINEAR=0, LIN_LATENCY=3, NUM_ROUNDS=4 -> no PRE_LIN pass; latency 1+4*5=21 cycles.
